// File: rtl/card_io_pkg.sv
// Shared constants and channel-state encoding for the card input frontend.
package card_io_pkg;

  localparam int NUM_BTN           = 3;
  localparam int NUM_SW            = 4;
  localparam int DB_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } ch_state_e;

endpackage

// File: rtl/card_input_frontend_if.sv
// Raw board pins in, debounced levels and press pulses out to the game core.
interface card_input_frontend_if;
  import card_io_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_SW-1:0]  sw_raw;
  logic               btn_0;
  logic               btn_1;
  logic               btn_2;
  logic [NUM_BTN-1:0] btn_held;
  logic [NUM_SW-1:0]  sw;
  logic               sw_changed;

  // Board / stimulus side: drives the pins, observes the cleaned outputs.
  modport master (
    output btn_raw, sw_raw,
    input  btn_0, btn_1, btn_2, btn_held, sw, sw_changed
  );

  // Frontend side.
  modport slave (
    input  btn_raw, sw_raw,
    output btn_0, btn_1, btn_2, btn_held, sw, sw_changed
  );

endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, level FSM.
//
//   state   | meaning
//   --------+----------------------------------------------
//   IDLE_LO | stable level 0, synchronized input agrees
//   CHK_HI  | stable level 0, input high, counting toward accept
//   IDLE_HI | stable level 1, synchronized input agrees
//   CHK_LO  | stable level 1, input low, counting toward accept
module debounce_ch
  import card_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic rise_nxt,
  output logic fall_nxt
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW:0] DB_TC = (CW + 1)'(DB_CYCLES);

  localparam logic [1:0] ST_IDLE_LO = IDLE_LO;
  localparam logic [1:0] ST_CHK_HI  = CHK_HI;
  localparam logic [1:0] ST_IDLE_HI = IDLE_HI;
  localparam logic [1:0] ST_CHK_LO  = CHK_LO;

  logic [1:0]    sync_q;
  logic          sync;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic          tc_hit;

  assign sync    = sync_q[1];
  assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);
  assign tc_hit  = (cnt_inc == DB_TC);

  // Two-stage synchronizer for the asynchronous pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw};
  end

  // Next state: the IDLE state of a level behaves like its CHK state with a zero
  // count, so a DB_CYCLES of 1 accepts on the very first disagreeing sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    case (state_q)
      ST_IDLE_LO, ST_CHK_HI: begin
        if (sync) begin
          if (tc_hit) begin
            state_d  = ST_IDLE_HI;
            rise_nxt = 1'b1;
          end else begin
            state_d = ST_CHK_HI;
            cnt_d   = cnt_inc[CW-1:0];
          end
        end else begin
          state_d = ST_IDLE_LO;
        end
      end
      ST_IDLE_HI, ST_CHK_LO: begin
        if (!sync) begin
          if (tc_hit) begin
            state_d  = ST_IDLE_LO;
            fall_nxt = 1'b1;
          end else begin
            state_d = ST_CHK_LO;
            cnt_d   = cnt_inc[CW-1:0];
          end
        end else begin
          state_d = ST_IDLE_HI;
        end
      end
      default: state_d = ST_IDLE_LO;
    endcase
  end

  // State, counter, stable level and edge pulses all register on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE_LO;
      cnt_q   <= '0;
      stable  <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stable  <= (state_d == ST_IDLE_HI) || (state_d == ST_CHK_LO);
      rise    <= rise_nxt;
      fall    <= fall_nxt;
    end
  end

endmodule

// File: rtl/card_input_frontend.sv
// Debounces the three push buttons and four slide switches for the game core.
module card_input_frontend
  import card_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  card_input_frontend_if.slave bus
);

  localparam int NCH = NUM_BTN + NUM_SW;

  logic [NCH-1:0] raw_all;
  logic [NCH-1:0] stable_q;
  logic [NCH-1:0] rise_q;
  logic [NCH-1:0] fall_q;
  logic [NCH-1:0] rise_nxt;
  logic [NCH-1:0] fall_nxt;
  logic           sw_change_nxt;
  logic           sw_changed_q;
  logic           unused_pulses;

  assign raw_all = {bus.sw_raw, bus.btn_raw};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw_all[i]),
      .stable   (stable_q[i]),
      .rise     (rise_q[i]),
      .fall     (fall_q[i]),
      .rise_nxt (rise_nxt[i]),
      .fall_nxt (fall_nxt[i])
    );
  end

  // The channels' pre-register pulses are used so sw_changed lands on the
  // same edge as the sw level it reports.
  assign sw_change_nxt = |{rise_nxt[NCH-1:NUM_BTN], fall_nxt[NCH-1:NUM_BTN]};

  // Single change flag for the whole switch bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sw_changed_q <= 1'b0;
    else     sw_changed_q <= sw_change_nxt;
  end

  assign bus.btn_0      = rise_q[0];
  assign bus.btn_1      = rise_q[1];
  assign bus.btn_2      = rise_q[2];
  assign bus.btn_held   = stable_q[NUM_BTN-1:0];
  assign bus.sw         = stable_q[NCH-1:NUM_BTN];
  assign bus.sw_changed = sw_changed_q;

  // Release pulses on buttons and registered pulses on switches have no consumer.
  assign unused_pulses = ^{fall_q, rise_q[NCH-1:NUM_BTN], rise_nxt[NUM_BTN-1:0],
                           fall_nxt[NUM_BTN-1:0]};

endmodule

// File: tb/tb_card_input_frontend.sv
// Directed bench for card_input_frontend with DB_CYCLES=4.
module tb_card_input_frontend;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  card_input_frontend_if bus ();

  card_input_frontend #(.DB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;
    logic [3:0] swi;
    logic [2:0] pulse;
    logic [2:0] held;
    logic [3:0] swo;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_rows(int n, logic [2:0] b, logic [3:0] s, logic [2:0] p,
                                   logic [2:0] h, logic [3:0] so, logic c);
    for (int i = 0; i < n; i++) vecs.push_back('{b, s, p, h, so, c});
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] all_outs();
    return {4'h0, bus.btn_2, bus.btn_1, bus.btn_0, bus.btn_held, bus.sw, bus.sw_changed};
  endfunction

  initial begin
    // Scenario table; one row per clock edge, edge 1 is the first row with new inputs.
    // clean press btn0, held 20, then release
    add_rows(3,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(5,  3'b001, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(1,  3'b001, 4'h0, 3'b001, 3'b001, 4'h0, 1'b0);
    add_rows(14, 3'b001, 4'h0, 3'b000, 3'b001, 4'h0, 1'b0);
    add_rows(5,  3'b000, 4'h0, 3'b000, 3'b001, 4'h0, 1'b0);
    add_rows(5,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    // release / repress: press hold 10, release hold 10, press
    add_rows(5,  3'b001, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(1,  3'b001, 4'h0, 3'b001, 3'b001, 4'h0, 1'b0);
    add_rows(4,  3'b001, 4'h0, 3'b000, 3'b001, 4'h0, 1'b0);
    add_rows(5,  3'b000, 4'h0, 3'b000, 3'b001, 4'h0, 1'b0);
    add_rows(5,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(5,  3'b001, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(1,  3'b001, 4'h0, 3'b001, 3'b001, 4'h0, 1'b0);
    add_rows(4,  3'b001, 4'h0, 3'b000, 3'b001, 4'h0, 1'b0);
    add_rows(5,  3'b000, 4'h0, 3'b000, 3'b001, 4'h0, 1'b0);
    add_rows(5,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    // bounce on btn1 then held high
    add_rows(2,  3'b010, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(2,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(2,  3'b010, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(2,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(5,  3'b010, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(1,  3'b010, 4'h0, 3'b010, 3'b010, 4'h0, 1'b0);
    add_rows(4,  3'b010, 4'h0, 3'b000, 3'b010, 4'h0, 1'b0);
    add_rows(5,  3'b000, 4'h0, 3'b000, 3'b010, 4'h0, 1'b0);
    add_rows(5,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    // glitch on btn2, 3 cycles: rejected
    add_rows(3,  3'b100, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(8,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    // exactly 4 cycles on btn2: accepted, then released
    add_rows(4,  3'b100, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(1,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(1,  3'b000, 4'h0, 3'b100, 3'b100, 4'h0, 1'b0);
    add_rows(3,  3'b000, 4'h0, 3'b000, 3'b100, 4'h0, 1'b0);
    add_rows(3,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    // switches 0000 -> 1010 -> 0000
    add_rows(5,  3'b000, 4'ha, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(1,  3'b000, 4'ha, 3'b000, 3'b000, 4'ha, 1'b1);
    add_rows(5,  3'b000, 4'ha, 3'b000, 3'b000, 4'ha, 1'b0);
    add_rows(5,  3'b000, 4'h0, 3'b000, 3'b000, 4'ha, 1'b0);
    add_rows(1,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b1);
    add_rows(3,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    // simultaneous press on all buttons
    add_rows(5,  3'b111, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);
    add_rows(1,  3'b111, 4'h0, 3'b111, 3'b111, 4'h0, 1'b0);
    add_rows(3,  3'b111, 4'h0, 3'b000, 3'b111, 4'h0, 1'b0);
    add_rows(5,  3'b000, 4'h0, 3'b000, 3'b111, 4'h0, 1'b0);
    add_rows(3,  3'b000, 4'h0, 3'b000, 3'b000, 4'h0, 1'b0);

    rst = 1'b1;
    bus.btn_raw = 3'b000;
    bus.sw_raw  = 4'h0;
    repeat (3) tick();
    check("reset_outputs", all_outs(), 16'h0);
    rst = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      bus.btn_raw = vecs[r].btn;
      bus.sw_raw  = vecs[r].swi;
      tick();
      check($sformatf("row%0d_pulse", r), {13'h0, bus.btn_2, bus.btn_1, bus.btn_0},
            {13'h0, vecs[r].pulse});
      check($sformatf("row%0d_held", r), {13'h0, bus.btn_held}, {13'h0, vecs[r].held});
      check($sformatf("row%0d_sw", r), {12'h0, bus.sw}, {12'h0, vecs[r].swo});
      check($sformatf("row%0d_swchg", r), {15'h0, bus.sw_changed}, {15'h0, vecs[r].chg});
    end

    // Reset two counts into a debounce: no pulse during or after; held input re-pressed.
    bus.btn_raw = 3'b001;
    repeat (4) tick();
    check("pre_reset_idle", all_outs(), 16'h0);
    #2 rst = 1'b1;
    #1 check("rst_async_zero", all_outs(), 16'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst_hold%0d", i), all_outs(), 16'h0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("post_rst_e%0d_btn0", e), {15'h0, bus.btn_0}, {15'h0, (e == 6)});
      check($sformatf("post_rst_e%0d_held", e), {13'h0, bus.btn_held},
            {13'h0, 2'b00, (e >= 6)});
    end

    // Reset while a level is already accepted clears it immediately, without a clock.
    #2 rst = 1'b1;
    #1 check("rst_clears_held", all_outs(), 16'h0);
    tick();
    bus.btn_raw = 3'b000;
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("after_rst2_e%0d", e), all_outs(), 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
